// File: rtl/code_sequencer_if.sv
// Memory-port and playback-controller signals shared by the code sequencer
// (master) and the memory mux / code playback controller (slave).
interface code_sequencer_if #(
    parameter int ADDRESS_BITS = 13
);
    logic                    mem_owner_out;
    logic [ADDRESS_BITS-1:0] mem_address_out;
    logic [7:0]              mem_data_in;
    logic [ADDRESS_BITS-1:0] ctrl_base_address_out;
    logic                    ctrl_start_out;
    logic                    ctrl_abort_out;
    logic                    ctrl_busy_in;
    logic                    ctrl_fail_in;

    modport master (
        output mem_owner_out,
        output mem_address_out,
        input  mem_data_in,
        output ctrl_base_address_out,
        output ctrl_start_out,
        output ctrl_abort_out,
        input  ctrl_busy_in,
        input  ctrl_fail_in
    );

    modport slave (
        input  mem_owner_out,
        input  mem_address_out,
        output mem_data_in,
        input  ctrl_base_address_out,
        input  ctrl_start_out,
        input  ctrl_abort_out,
        output ctrl_busy_in,
        output ctrl_fail_in
    );
endinterface

// File: rtl/code_sequencer.sv
// Playback scheduler: walks a per-region code table, hands each code base address
// to the playback controller, waits for it, then inserts a fixed inter-code gap.
module code_sequencer #(
    parameter int ADDRESS_BITS  = 13,
    parameter int CLK_MHZ       = 8,
    parameter int GAP_US        = 250,
    parameter int GAP_BITS      = 16,
    parameter int TABLE_BASE_0  = 0,
    parameter int TABLE_BASE_1  = 256,
    parameter int START_TIMEOUT = 15
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic             region_in,
    output logic             busy_out,
    output logic             fail_out,
    output logic             done_strobe_out,
    output logic [7:0]       code_index_out,
    code_sequencer_if.master bus
);

    localparam int TO_BITS = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [GAP_BITS-1:0]     GAP_LOAD   = GAP_BITS'(GAP_US * CLK_MHZ - 1);
    localparam logic [TO_BITS-1:0]      TO_LAST    = TO_BITS'(START_TIMEOUT - 1);
    localparam logic [ADDRESS_BITS-1:0] BASE_0     = ADDRESS_BITS'(TABLE_BASE_0);
    localparam logic [ADDRESS_BITS-1:0] BASE_1     = ADDRESS_BITS'(TABLE_BASE_1);
    localparam logic [ADDRESS_BITS-1:0] ADDR_ONE   = ADDRESS_BITS'(2'd1);
    localparam logic [ADDRESS_BITS-1:0] ADDR_TWO   = ADDRESS_BITS'(2'd2);
    localparam logic [GAP_BITS-1:0]     GAP_ONE    = GAP_BITS'(1'b1);
    localparam logic [GAP_BITS-1:0]     GAP_ZERO   = GAP_BITS'(1'b0);
    localparam logic [TO_BITS-1:0]      TO_ONE     = TO_BITS'(1'b1);
    localparam logic [TO_BITS-1:0]      TO_ZERO    = TO_BITS'(1'b0);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_READ_COUNT = 4'd1,
        S_READ_LO    = 4'd2,
        S_READ_HI    = 4'd3,
        S_START      = 4'd4,
        S_WAIT_BUSY  = 4'd5,
        S_WAIT_DONE  = 4'd6,
        S_GAP        = 4'd7,
        S_FAIL       = 4'd8
    } state_t;

    state_t                  state_r;
    logic                    start_d_r;
    logic                    rd_phase_r;
    logic [7:0]              count_r;
    logic [7:0]              lo_r;
    logic [ADDRESS_BITS-1:0] ptr_r;
    logic [GAP_BITS-1:0]     gap_r;
    logic [TO_BITS-1:0]      timeout_r;
    logic                    start_edge_s;
    logic                    active_s;

    // An entry is usable only if no bit above the memory address range is set.
    function automatic logic entry_in_range(input logic [15:0] entry);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i >= ADDRESS_BITS && entry[i]) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    assign start_edge_s = start_in & ~start_d_r;
    assign active_s     = (state_r != S_IDLE) && (state_r != S_FAIL);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r                   <= S_IDLE;
            start_d_r                 <= start_in;
            rd_phase_r                <= 1'b0;
            count_r                   <= 8'd0;
            lo_r                      <= 8'd0;
            ptr_r                     <= '0;
            gap_r                     <= '0;
            timeout_r                 <= '0;
            busy_out                  <= 1'b0;
            fail_out                  <= 1'b0;
            done_strobe_out           <= 1'b0;
            code_index_out            <= 8'd0;
            bus.mem_owner_out         <= 1'b0;
            bus.mem_address_out       <= '0;
            bus.ctrl_base_address_out <= '0;
            bus.ctrl_start_out        <= 1'b0;
            bus.ctrl_abort_out        <= 1'b0;
        end else begin
            start_d_r          <= start_in;
            done_strobe_out    <= 1'b0;
            bus.ctrl_start_out <= 1'b0;
            bus.ctrl_abort_out <= 1'b0;

            if (start_edge_s && active_s) begin
                // Button pressed mid-sequence: abort, keep the index for inspection.
                state_r            <= S_IDLE;
                busy_out           <= 1'b0;
                bus.mem_owner_out  <= 1'b0;
                bus.ctrl_abort_out <= 1'b1;
                rd_phase_r         <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE, S_FAIL: begin
                        if (start_edge_s) begin
                            state_r             <= S_READ_COUNT;
                            fail_out            <= 1'b0;
                            busy_out            <= 1'b1;
                            rd_phase_r          <= 1'b0;
                            bus.mem_owner_out   <= 1'b1;
                            bus.mem_address_out <= region_in ? BASE_1 : BASE_0;
                        end else begin
                            state_r <= state_r;
                        end
                    end

                    S_READ_COUNT: begin
                        if (!rd_phase_r) begin
                            rd_phase_r <= 1'b1;
                        end else begin
                            rd_phase_r <= 1'b0;
                            count_r    <= bus.mem_data_in;
                            if (bus.mem_data_in == 8'd0) begin
                                state_r           <= S_IDLE;
                                busy_out          <= 1'b0;
                                bus.mem_owner_out <= 1'b0;
                                done_strobe_out   <= 1'b1;
                            end else begin
                                state_r             <= S_READ_LO;
                                code_index_out      <= 8'd0;
                                ptr_r               <= bus.mem_address_out + ADDR_ONE;
                                bus.mem_address_out <= bus.mem_address_out + ADDR_ONE;
                            end
                        end
                    end

                    S_READ_LO: begin
                        // Phase 0 presents the high-byte address; phase 1 sees the low byte.
                        if (!rd_phase_r) begin
                            rd_phase_r          <= 1'b1;
                            bus.mem_address_out <= ptr_r + ADDR_ONE;
                        end else begin
                            rd_phase_r <= 1'b0;
                            lo_r       <= bus.mem_data_in;
                            state_r    <= S_READ_HI;
                        end
                    end

                    S_READ_HI: begin
                        bus.mem_owner_out <= 1'b0;
                        if (entry_in_range({bus.mem_data_in, lo_r})) begin
                            state_r                   <= S_START;
                            bus.ctrl_base_address_out <= ADDRESS_BITS'({bus.mem_data_in, lo_r});
                            bus.ctrl_start_out        <= 1'b1;
                        end else begin
                            state_r            <= S_FAIL;
                            fail_out           <= 1'b1;
                            busy_out           <= 1'b0;
                            bus.ctrl_abort_out <= 1'b1;
                        end
                    end

                    S_START: begin
                        state_r   <= S_WAIT_BUSY;
                        timeout_r <= TO_ZERO;
                    end

                    S_WAIT_BUSY: begin
                        if (bus.ctrl_busy_in) begin
                            state_r <= S_WAIT_DONE;
                        end else if (timeout_r == TO_LAST) begin
                            state_r            <= S_FAIL;
                            fail_out           <= 1'b1;
                            busy_out           <= 1'b0;
                            bus.ctrl_abort_out <= 1'b1;
                        end else begin
                            timeout_r <= timeout_r + TO_ONE;
                        end
                    end

                    S_WAIT_DONE: begin
                        // A failure reported together with busy falling still counts as failure.
                        if (bus.ctrl_fail_in) begin
                            state_r            <= S_FAIL;
                            fail_out           <= 1'b1;
                            busy_out           <= 1'b0;
                            bus.ctrl_abort_out <= 1'b1;
                        end else if (!bus.ctrl_busy_in) begin
                            state_r <= S_GAP;
                            gap_r   <= GAP_LOAD;
                        end else begin
                            state_r <= S_WAIT_DONE;
                        end
                    end

                    S_GAP: begin
                        if (gap_r != GAP_ZERO) begin
                            gap_r <= gap_r - GAP_ONE;
                        end else if (code_index_out == count_r - 8'd1) begin
                            state_r         <= S_IDLE;
                            busy_out        <= 1'b0;
                            done_strobe_out <= 1'b1;
                        end else begin
                            state_r             <= S_READ_LO;
                            rd_phase_r          <= 1'b0;
                            code_index_out      <= code_index_out + 8'd1;
                            ptr_r               <= ptr_r + ADDR_TWO;
                            bus.mem_address_out <= ptr_r + ADDR_TWO;
                            bus.mem_owner_out   <= 1'b1;
                        end
                    end

                    default: begin
                        state_r           <= S_IDLE;
                        busy_out          <= 1'b0;
                        bus.mem_owner_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
